// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and defaults for the fetch next-PC / redirect controller.
package fetch_redirect_ctrl_pkg;

  localparam int unsigned PC_MSB              = 31;
  localparam int unsigned DRAIN_CYCLES_DFLT   = 3;
  localparam int unsigned DRAIN_CNT_W         = 4;

  typedef logic [PC_MSB:0] pc_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SHADOW = 2'd1,
    DRAIN  = 2'd2
  } redirect_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl_drain_counter.sv
// Loadable down-counter; tc_o is registered and high while the count equals 1.
module fetch_redirect_ctrl_drain_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == CNT_W'(1));
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC register and redirect arbitration: commit redirect > rename misdirect > stall > prediction.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned     WIDTH        = 31,
  parameter logic [WIDTH:0]  RESET_PC     = '0,
  parameter int unsigned     DRAIN_CYCLES = DRAIN_CYCLES_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetchStall,
  input  logic [WIDTH:0]   predictedPC,
  input  logic             misdirect,
  input  logic [WIDTH:0]   validAddress,
  input  logic             commitRedirect,
  input  logic [WIDTH:0]   commitTarget,
  output logic [WIDTH:0]   PC,
  output logic             pcValid,
  output logic             flushFront,
  output logic             flushAll,
  output logic             busy
);

  redirect_state_t state_q, state_d;
  logic [WIDTH:0]  pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            flush_front_q, flush_front_d;
  logic            flush_all_q, flush_all_d;
  logic            busy_q, busy_d;
  logic            cnt_load, cnt_dec, cnt_tc;
  logic            advance;

  fetch_redirect_ctrl_drain_counter #(
    .CNT_W (DRAIN_CNT_W)
  ) u_drain_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (DRAIN_CNT_W'(DRAIN_CYCLES)),
    .dec_i      (cnt_dec),
    .tc_o       (cnt_tc)
  );

  // PC only moves on once the current PC has actually been presented as a valid fetch.
  assign advance = pc_valid_q && !fetchStall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush_front_d = 1'b0;
    flush_all_d   = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;

    if (commitRedirect) begin
      pc_d          = commitTarget;
      flush_front_d = 1'b1;
      flush_all_d   = 1'b1;
      cnt_load      = 1'b1;
      state_d       = DRAIN;
    end else begin
      case (state_q)
        RUN: begin
          if (misdirect) begin
            pc_d          = validAddress;
            flush_front_d = 1'b1;
            state_d       = SHADOW;
          end else if (advance) begin
            pc_d = predictedPC;
          end
        end
        SHADOW: begin
          state_d = RUN;
          if (advance) begin
            pc_d = predictedPC;
          end
        end
        DRAIN: begin
          cnt_dec = 1'b1;
          if (cnt_tc) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    pc_valid_d = (state_d != DRAIN);
    busy_d     = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      pc_valid_q    <= 1'b0;
      flush_front_q <= 1'b0;
      flush_all_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      flush_front_q <= flush_front_d;
      flush_all_q   <= flush_all_d;
      busy_q        <= busy_d;
    end
  end

  assign PC         = pc_q;
  assign pcValid    = pc_valid_q;
  assign flushFront = flush_front_q;
  assign flushAll   = flush_all_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed and randomized checks of fetch_redirect_ctrl against an event-level reference model.
module tb_fetch_redirect_ctrl;
  import fetch_redirect_ctrl_pkg::*;

  localparam int unsigned W      = 31;
  localparam pc_t         RST_PC = 32'd0;
  localparam int          DRAIN  = 3;

  logic clk;
  logic reset;
  logic fetchStall;
  pc_t  predictedPC;
  logic misdirect;
  pc_t  validAddress;
  logic commitRedirect;
  pc_t  commitTarget;
  pc_t  PC;
  logic pcValid;
  logic flushFront;
  logic flushAll;
  logic busy;

  fetch_redirect_ctrl #(
    .WIDTH        (W),
    .RESET_PC     (RST_PC),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetchStall     (fetchStall),
    .predictedPC    (predictedPC),
    .misdirect      (misdirect),
    .validAddress   (validAddress),
    .commitRedirect (commitRedirect),
    .commitTarget   (commitTarget),
    .PC             (PC),
    .pcValid        (pcValid),
    .flushFront     (flushFront),
    .flushAll       (flushAll),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outputs expressed as "invalid fetch cycles still owed" and "inside the shadow cycle".
  pc_t  exp_pc;
  logic exp_valid, exp_ff, exp_fa, exp_busy;
  int   drain_left;
  bit   shadow;
  bit   auto_pred;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    exp_ff = 1'b0;
    exp_fa = 1'b0;
    if (reset) begin
      exp_pc = RST_PC; exp_valid = 1'b0; exp_busy = 1'b0;
      drain_left = 0; shadow = 1'b0;
    end else if (commitRedirect) begin
      exp_pc = commitTarget; exp_ff = 1'b1; exp_fa = 1'b1;
      drain_left = DRAIN; shadow = 1'b0;
      exp_valid = 1'b0; exp_busy = 1'b1;
    end else if (drain_left > 0) begin
      drain_left--;
      exp_valid = (drain_left == 0);
      exp_busy  = (drain_left != 0);
    end else if (misdirect && !shadow) begin
      exp_pc = validAddress; exp_ff = 1'b1;
      shadow = 1'b1; exp_valid = 1'b1; exp_busy = 1'b1;
    end else begin
      if (exp_valid && !fetchStall) exp_pc = predictedPC;
      shadow = 1'b0; exp_valid = 1'b1; exp_busy = 1'b0;
    end
  endtask

  task automatic step();
    if (auto_pred) predictedPC = exp_pc + 32'd1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pc",         64'(PC),         64'(exp_pc));
    chk("pcValid",    64'(pcValid),    64'(exp_valid));
    chk("flushFront", 64'(flushFront), 64'(exp_ff));
    chk("flushAll",   64'(flushAll),   64'(exp_fa));
    chk("busy",       64'(busy),       64'(exp_busy));
  endtask

  initial begin
    reset = 1'b1; fetchStall = 1'b0; predictedPC = '0; misdirect = 1'b0;
    validAddress = '0; commitRedirect = 1'b0; commitTarget = '0;
    exp_pc = '0; exp_valid = 1'b0; exp_ff = 1'b0; exp_fa = 1'b0; exp_busy = 1'b0;
    drain_left = 0; shadow = 1'b0; auto_pred = 1'b1;

    // Reset then sequential run
    step(); step();
    chk("rst_pc", 64'(PC), 64'(RST_PC));
    chk("rst_valid", 64'(pcValid), 64'd0);
    reset = 1'b0;
    step();
    chk("first_pc", 64'(PC), 64'd0);
    chk("first_valid", 64'(pcValid), 64'd1);
    step(); chk("seq_pc1", 64'(PC), 64'd1);
    step(); chk("seq_pc2", 64'(PC), 64'd2);
    step(); chk("seq_pc3", 64'(PC), 64'd3);
    step(); step();
    chk("seq_pc5", 64'(PC), 64'd5);

    // Rename redirect, then an ignored misdirect in the shadow cycle
    misdirect = 1'b1; validAddress = 32'd40;
    step();
    chk("ren_pc", 64'(PC), 64'd40);
    chk("ren_ff", 64'(flushFront), 64'd1);
    chk("ren_fa", 64'(flushAll), 64'd0);
    validAddress = 32'd99;
    step();
    chk("shadow_ignore_pc", 64'(PC), 64'd41);
    chk("shadow_ff_low", 64'(flushFront), 64'd0);
    misdirect = 1'b0;
    step();

    // Commit redirect with drain
    commitRedirect = 1'b1; commitTarget = 32'd100;
    step();
    chk("cmt_pc", 64'(PC), 64'd100);
    chk("cmt_fa", 64'(flushAll), 64'd1);
    chk("cmt_valid_n1", 64'(pcValid), 64'd0);
    commitRedirect = 1'b0;
    step(); chk("cmt_valid_n2", 64'(pcValid), 64'd0);
    step(); chk("cmt_valid_n3", 64'(pcValid), 64'd0);
    step();
    chk("cmt_valid_n4", 64'(pcValid), 64'd1);
    chk("cmt_pc_n4", 64'(PC), 64'd100);
    step();

    // Simultaneous commit and misdirect
    commitRedirect = 1'b1; commitTarget = 32'd200;
    misdirect = 1'b1; validAddress = 32'd300;
    step();
    chk("sim_pc", 64'(PC), 64'd200);
    chk("sim_fa", 64'(flushAll), 64'd1);
    chk("sim_busy", 64'(busy), 64'd1);
    commitRedirect = 1'b0; misdirect = 1'b0;
    step(); step(); step(); step();

    // Stall interplay
    misdirect = 1'b1; validAddress = 32'd7;
    step();
    misdirect = 1'b0; fetchStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_hold", 64'(PC), 64'd7);
    end
    misdirect = 1'b1; validAddress = 32'd20;
    step();
    chk("stall_redirect", 64'(PC), 64'd20);
    misdirect = 1'b0; fetchStall = 1'b0;
    step();

    // Reset mid-drain
    commitRedirect = 1'b1; commitTarget = 32'd500;
    step();
    commitRedirect = 1'b0; reset = 1'b1;
    step();
    chk("rdr_pc", 64'(PC), 64'(RST_PC));
    chk("rdr_busy", 64'(busy), 64'd0);
    chk("rdr_fa", 64'(flushAll), 64'd0);
    reset = 1'b0;
    step();
    chk("rdr_resume_valid", 64'(pcValid), 64'd1);
    step();
    chk("rdr_resume_pc", 64'(PC), 64'(RST_PC + 32'd1));

    // Randomized traffic against the model
    auto_pred = 1'b0;
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 59) == 0);
      commitRedirect = ($urandom_range(0, 11) == 0);
      misdirect      = ($urandom_range(0, 4) == 0);
      fetchStall     = ($urandom_range(0, 3) == 0);
      predictedPC    = pc_t'($urandom);
      validAddress   = pc_t'($urandom);
      commitTarget   = pc_t'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
